rb_wb_ctrl: RTL and testbench
=============================

// Module: rb_wb_ctrl
// PURPOSE
// Writeback/port controller in front of reg_bank. Merges ALU and LSU results into
// reg_bank's single write port and shares reg_bank addr_a between writes and
// decode's port-A reads. Keeps a per-register busy scoreboard for issue-stall logic.
// Drives reg_bank reg_wen (active-low), addr_a, data_i.
// PARAMETERS
// FIFO_DEPTH    4   ALU result queue depth, power of 2, >=2
// MAX_WR_BURST  3   max consecutive write beats while a read is pending, >=1
// PORTS
// clk        in   1   core clock
// rst        in   1   asynchronous reset, active-high
// alu_valid  in   1   ALU result valid
// alu_ready  out  1   ALU result accepted (= !fifo_full)
// alu_rd     in   5   ALU destination register
// alu_data   in   32  ALU result
// lsu_valid  in   1   load data valid
// lsu_ready  out  1   load data consumed this cycle (combinational)
// lsu_rd     in   5   load destination register
// lsu_data   in   32  load data
// iss_set    in   1   issue marks iss_rd busy
// iss_rd     in   5   issued destination register
// rd_req     in   1   decode requests port-A read
// rd_addr    in   5   decode read address
// rd_grant   out  1   registered; high in the cycle rb_addr_a = granted rd_addr
// rb_wen     out  1   to reg_bank reg_wen; 0 = write
// rb_addr_a  out  5   to reg_bank addr_a
// rb_data    out  32  to reg_bank data_i
// busy       out  32  scoreboard; bit n = write to rn pending
// BEHAVIOUR
// - Reset (async, on rst high): rb_wen=1, rb_addr_a=0, rb_data=0, rd_grant=0,
//   busy=0, FIFO empty, burst_cnt=0. Reset mid-operation discards queued results.
//   Upstream re-issues.
// - ALU results are pushed into the FIFO on alu_valid&&alu_ready. There is no bypass.
//   When the FIFO is full, alu_ready=0 even if a pop happens in the same cycle.
// - Per-cycle selection. Candidate is the LSU if lsu_valid, else the FIFO head if
//   non-empty. The LSU always beats the FIFO.
//   - read_win = rd_req && (no candidate || burst_cnt==MAX_WR_BURST).
//   - If read_win: next edge rb_wen<=1, rb_addr_a<=rd_addr, rd_grant<=1.
//     No candidate is consumed and lsu_ready=0.
//   - Else if candidate: candidate is consumed (lsu_ready=1 or FIFO pop).
//     Next edge rb_wen<=0, rb_addr_a<=rd, rb_data<=data, rd_grant<=0.
//   - Else: rb_wen<=1, rd_grant<=0, rb_addr_a and rb_data hold.
// - rd==0 candidate: consumed normally, but rb_wen stays 1 for that beat. It counts
//   as a write beat for burst_cnt.
// - Latency: LSU consume to rb_wen low is 1 cycle. ALU accept to rb_wen low is at
//   least 2 cycles.
// - burst_cnt: +1 on a write beat taken while rd_req=1, saturates at MAX_WR_BURST.
//   Cleared on read_win or when rd_req=0.
// - Scoreboard: iss_set sets busy[iss_rd] (ignored for rd 0). A consumed candidate
//   clears busy[rd] on the same edge rb_wen goes low. Set and clear on the same
//   index in the same cycle: set wins. busy[0] is always 0.
// - rd_req with a write in progress: decode holds rd_req and rd_addr until it sees
//   rd_grant. Grant is never lost; starvation is bounded by MAX_WR_BURST.
// - FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
// STRUCTURE
// - Shared package sneva_pkg: XLEN=32, REG_AW=5, NREGS=32, REG_ZERO=5'd0.
// - Sub-module rb_wb_fifo: synchronous FIFO with push/pop/full/empty, async
//   active-high reset. Selection, burst counter, scoreboard and output registers
//   stay in rb_wb_ctrl.
// TESTING
// 1 Reset: assert rst mid-stream -> rb_wen=1, busy=0, alu_ready=1, rd_grant=0
//   immediately, without waiting for a clk edge.
// 2 ALU single: iss_set rd=5, then alu_valid rd=5 data=32'hDEADBEEF ->
//   2 cycles later rb_wen=0, rb_addr_a=5, rb_data=DEADBEEF; busy[5] 1->0 on the same edge.
// 3 Collision: lsu rd=3 data=1 and alu rd=4 data=2 in the same cycle -> r3 written
//   at N+1, r4 at N+2.
// 4 FIFO full: lsu_valid held high, 5 back-to-back ALU results -> 4 accepted,
//   alu_ready=0 on the 5th; drain order preserved after lsu_valid drops.
// 5 Starvation: rd_req=1 rd_addr=7 with lsu_valid held high, MAX_WR_BURST=3 ->
//   3 write beats, then 1 cycle rb_wen=1, rb_addr_a=7, rd_grant=1, then writes resume.
// 6 Zero reg: lsu_valid rd=0 data=FFFFFFFF -> lsu_ready=1, rb_wen stays 1,
//   busy unchanged.

Source files
------------

// File: rtl/sneva_pkg.sv
//------------------------------------------------------------------------------
// Module   : sneva_pkg
// Brief    : Shared register-file widths and the writeback entry type.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sneva_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/rb_wb_fifo.sv
//------------------------------------------------------------------------------
// Module   : rb_wb_fifo
// Brief    : Synchronous FIFO holding ALU results awaiting the write port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rb_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rb_wb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rb_wb_ctrl
// Brief    : Merges ALU/LSU results onto reg_bank's write port, arbitrates
//            port A against decode reads and tracks the busy scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rb_wb_ctrl
    import sneva_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MAX_WR_BURST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              iss_set,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              rd_req,
    input  logic [REG_AW-1:0] rd_addr,
    output logic              rd_grant,
    output logic              rb_wen,
    output logic [REG_AW-1:0] rb_addr_a,
    output logic [XLEN-1:0]   rb_data,
    output logic [NREGS-1:0]  busy
);

    localparam int BW = $clog2(MAX_WR_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_WR_BURST);

    wb_entry_t         fifo_din;
    wb_entry_t         fifo_dout;
    wb_entry_t         cand;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              cand_valid;
    logic              read_win;
    logic              take;

    logic              wen_q,   wen_d;
    logic              grant_q, grant_d;
    logic [REG_AW-1:0] addr_q,  addr_d;
    logic [XLEN-1:0]   data_q,  data_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [NREGS-1:0]  busy_q,  busy_d;

    assign fifo_din.rd   = alu_rd;
    assign fifo_din.data = alu_data;

    rb_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (alu_valid && alu_ready),
        .din_i   (fifo_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // LSU always outranks queued ALU results.
    assign cand       = lsu_valid ? '{rd: lsu_rd, data: lsu_data} : fifo_dout;
    assign cand_valid = lsu_valid || !fifo_empty;
    assign read_win   = rd_req && (!cand_valid || (burst_q == BURST_MAX));
    assign take       = cand_valid && !read_win;

    assign alu_ready  = !fifo_full;
    assign lsu_ready  = take && lsu_valid;
    assign fifo_pop   = take && !lsu_valid;

    always_comb begin
        wen_d   = 1'b1;
        grant_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        burst_d = burst_q;
        busy_d  = busy_q;

        if (read_win) begin
            addr_d  = rd_addr;
            grant_d = 1'b1;
        end else if (take) begin
            wen_d          = (cand.rd == REG_ZERO);
            addr_d         = cand.rd;
            data_d         = cand.data;
            busy_d[cand.rd] = 1'b0;
        end

        if (!rd_req || read_win) begin
            burst_d = '0;
        end else if (take && (burst_q != BURST_MAX)) begin
            burst_d = burst_q + BW'(1);
        end

        // Issue set applied after the clear so it wins on a same-index collision.
        if (iss_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b1;
            grant_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            burst_q <= '0;
            busy_q  <= '0;
        end else begin
            wen_q   <= wen_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            burst_q <= burst_d;
            busy_q  <= busy_d;
        end
    end

    assign rb_wen    = wen_q;
    assign rd_grant  = grant_q;
    assign rb_addr_a = addr_q;
    assign rb_data   = data_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_rb_wb_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_rb_wb_ctrl
// Brief    : Self-checking bench for rb_wb_ctrl (vector table plus write scoreboard).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_rd = 5'd0;
    logic [31:0] lsu_data = 32'd0;
    logic        iss_set = 1'b0;
    logic [4:0]  iss_rd = 5'd0;
    logic        rd_req = 1'b0;
    logic [4:0]  rd_addr = 5'd0;
    logic        rd_grant;
    logic        rb_wen;
    logic [4:0]  rb_addr_a;
    logic [31:0] rb_data;
    logic [31:0] busy;

    int n_chk  = 0;
    int n_pass = 0;

    rb_wb_ctrl #(
        .FIFO_DEPTH   (4),
        .MAX_WR_BURST (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_set   (iss_set),
        .iss_rd    (iss_rd),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_grant  (rd_grant),
        .rb_wen    (rb_wen),
        .rb_addr_a (rb_addr_a),
        .rb_data   (rb_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        is;
        logic [4:0]  ird;
        logic        rq;
        logic [4:0]  raddr;
        logic        e_lrdy;
        logic        e_wen;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_grant;
        logic [31:0] e_busy;
        logic        chk_ad;
    } vec_t;

    function automatic vec_t mk(
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
        input logic av, input logic [4:0] ard, input logic [31:0] adat,
        input logic is, input logic [4:0] ird,
        input logic rq, input logic [4:0] raddr,
        input logic e_lrdy, input logic e_wen, input logic [4:0] e_addr,
        input logic [31:0] e_data, input logic e_grant, input logic [31:0] e_busy,
        input logic chk_ad);
        vec_t v;
        v = '{lv, lrd, ldat, av, ard, adat, is, ird, rq, raddr,
              e_lrdy, e_wen, e_addr, e_data, e_grant, e_busy, chk_ad};
        return v;
    endfunction

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    bit  sb_en = 1'b0;

    // Every write that reaches reg_bank while enabled must match the queue head.
    always @(negedge clk) begin
        wr_t e;
        if (sb_en && rb_wen === 1'b0) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: got write r%0d=0x%0h, expected none", rb_addr_a, rb_data);
            end else begin
                e = sb.pop_front();
                chk("sb_addr", {27'd0, rb_addr_a}, {27'd0, e.rd});
                chk("sb_data", rb_data, e.data);
            end
        end
    end

    task automatic idle();
        lsu_valid = 1'b0; alu_valid = 1'b0; iss_set = 1'b0; rd_req = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 30 && sb.size() != 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk(name, sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        wr_t  alu_q[$];
        vec_t v;

        // Reset values appear without any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_wen",   {31'd0, rb_wen}, 32'd1);
        chk("rst_addr",  {27'd0, rb_addr_a}, 32'd0);
        chk("rst_data",  rb_data, 32'd0);
        chk("rst_grant", {31'd0, rd_grant}, 32'd0);
        chk("rst_busy",  busy, 32'd0);
        chk("rst_ardy",  {31'd0, alu_ready}, 32'd1);
        chk("rst_lrdy",  {31'd0, lsu_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;

        // ALU single, collision with set-wins, zero register, starvation, idle read.
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd5, 1'b0,5'd0,  1'b0, 1'b1,5'd0,32'h0,        1'b0,32'h20, 1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b1,5'd0,32'h0,        1'b0,32'h20, 1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b0,5'd5,32'hDEADBEEF, 1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b1,5'd3,32'h1,        1'b1,5'd4,32'h2,        1'b1,5'd3, 1'b0,5'd0,  1'b1, 1'b0,5'd3,32'h1,        1'b0,32'h8,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b0,5'd4,32'h2,        1'b0,32'h8,  1'b1));
        tbl.push_back(mk(1'b1,5'd3,32'h33,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b1, 1'b0,5'd3,32'h33,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b1,5'd3,32'h33,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd9, 1'b0,5'd0,  1'b0, 1'b1,5'd3,32'h33,       1'b0,32'h200,1'b1));
        tbl.push_back(mk(1'b1,5'd0,32'hFFFFFFFF, 1'b0,5'd0,32'h0,        1'b1,5'd0, 1'b0,5'd0,  1'b1, 1'b1,5'd0,32'h0,        1'b0,32'h200,1'b0));
        tbl.push_back(mk(1'b1,5'd9,32'h99,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b1, 1'b0,5'd9,32'h99,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b1,5'd1,32'h11,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,5'd7,  1'b1, 1'b0,5'd1,32'h11,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b1,5'd2,32'h12,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,5'd7,  1'b1, 1'b0,5'd2,32'h12,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b1,5'd3,32'h13,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,5'd7,  1'b1, 1'b0,5'd3,32'h13,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b1,5'd4,32'h14,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,5'd7,  1'b0, 1'b1,5'd7,32'h13,       1'b1,32'h0,  1'b1));
        tbl.push_back(mk(1'b1,5'd4,32'h14,       1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b1, 1'b0,5'd4,32'h14,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b1,5'd4,32'h14,       1'b0,32'h0,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b1,5'd12, 1'b0, 1'b1,5'd12,32'h14,      1'b1,32'h0,  1'b1));
        tbl.push_back(mk(1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 1'b0,5'd0,  1'b0, 1'b1,5'd12,32'h14,      1'b0,32'h0,  1'b1));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldat;
            alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
            iss_set = v.is; iss_rd = v.ird; rd_req = v.rq; rd_addr = v.raddr;
            #1;
            chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready}, {31'd0, v.e_lrdy});
            chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_rb_wen", i),   {31'd0, rb_wen},   {31'd0, v.e_wen});
            chk($sformatf("v%0d_rd_grant", i), {31'd0, rd_grant}, {31'd0, v.e_grant});
            chk($sformatf("v%0d_busy", i),     busy, v.e_busy);
            if (v.chk_ad) begin
                chk($sformatf("v%0d_rb_addr_a", i), {27'd0, rb_addr_a}, {27'd0, v.e_addr});
                chk($sformatf("v%0d_rb_data", i),   rb_data, v.e_data);
            end
        end
        @(negedge clk) idle();

        // FIFO full while the LSU holds the port; ALU drains in order afterwards.
        sb_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lsu_valid = 1'b1; lsu_rd = 5'(16 + k); lsu_data = 32'h100 + k;
            alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'hA0 + k;
            sb.push_back('{5'(16 + k), 32'h100 + k});
            #1;
            chk($sformatf("full%0d_alu_ready", k), {31'd0, alu_ready}, (k < 4) ? 32'd1 : 32'd0);
            chk($sformatf("full%0d_lsu_ready", k), {31'd0, lsu_ready}, 32'd1);
            if (k < 4) alu_q.push_back('{5'(20 + k), 32'hA0 + k});
        end
        @(negedge clk) idle();
        while (alu_q.size() != 0) sb.push_back(alu_q.pop_front());
        drain("full_drain");

        // Random ALU stream: one pop per cycle keeps the queue from filling.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom_range(1, 31));
            alu_data  = $urandom;
            #1;
            chk($sformatf("rnd%0d_alu_ready", k), {31'd0, alu_ready}, 32'd1);
            if (alu_valid) sb.push_back('{alu_rd, alu_data});
        end
        @(negedge clk) idle();
        drain("rnd_drain");
        sb_en = 1'b0;

        // Asynchronous reset mid-stream discards queued results.
        @(negedge clk);
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        iss_set = 1'b1; iss_rd = 5'd8;
        @(negedge clk);
        lsu_data = 32'h67; alu_rd = 5'd11; alu_data = 32'hBB; iss_set = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_wen",  {31'd0, rb_wen}, 32'd0);
        chk("pre_rst_busy", busy, 32'h100);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen",   {31'd0, rb_wen}, 32'd1);
        chk("mid_rst_busy",  busy, 32'd0);
        chk("mid_rst_ardy",  {31'd0, alu_ready}, 32'd1);
        chk("mid_rst_grant", {31'd0, rd_grant}, 32'd0);
        @(negedge clk) idle();
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_wen", k), {31'd0, rb_wen}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
